// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl: arbitrates pipeline/debug CSR accesses and sequences read-then-write on the CSR file.
// Optional `CSR_ACC_PERF_EN adds perf_acc_cnt / perf_cancel_cnt outputs.
module csr_access_ctrl #(
    parameter int unsigned NUM_W    = 14,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ARB_MODE = 0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              pl_req_valid,
    output logic              pl_req_ready,
    input  logic [1:0]        pl_op,
    input  logic [NUM_W-1:0]  pl_num,
    input  logic [DATA_W-1:0] pl_wdata,
    input  logic [DATA_W-1:0] pl_wmask,
    output logic              pl_rsp_valid,
    input  logic              pl_rsp_ready,
    output logic [DATA_W-1:0] pl_rdata,
    input  logic              dbg_req_valid,
    output logic              dbg_req_ready,
    input  logic [1:0]        dbg_op,
    input  logic [NUM_W-1:0]  dbg_num,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic [DATA_W-1:0] dbg_wmask,
    output logic              dbg_rsp_valid,
    input  logic              dbg_rsp_ready,
    output logic [DATA_W-1:0] dbg_rdata,
    input  logic              wb_ex,
    input  logic              ertn_flush,
    output logic              csr_we,
    output logic [NUM_W-1:0]  csr_num,
    output logic [DATA_W-1:0] csr_wmask,
    output logic [DATA_W-1:0] csr_wvalue,
    input  logic [DATA_W-1:0] csr_rvalue,
    output logic              busy
`ifdef CSR_ACC_PERF_EN
    ,
    output logic [31:0]       perf_acc_cnt,
    output logic [31:0]       perf_cancel_cnt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RSP} state_t;
    typedef enum logic [1:0] {OP_RD = 2'b00, OP_WR = 2'b01, OP_XCHG = 2'b10, OP_RSV = 2'b11} op_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_last;   // 1: debug was granted last
    logic              r_owner;  // 1: debug owns the current access
    op_t               r_op;
    logic [NUM_W-1:0]  r_num;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_wmask;
    logic [DATA_W-1:0] r_csr_wmask;
    logic [DATA_W-1:0] r_csr_wvalue;
    logic [DATA_W-1:0] r_pl_rdata;
    logic [DATA_W-1:0] r_dbg_rdata;

    logic w_flush;
    logic w_pl_cand;
    logic w_dbg_cand;
    logic w_gnt_pl;
    logic w_gnt_dbg;
    logic w_is_write;
    logic w_pl_cancel;
    logic w_rsp_valid;
    logic w_hs;

    assign w_flush     = wb_ex | ertn_flush;
    // Gating with resetn keeps the ready outputs low while reset is held.
    assign w_pl_cand   = resetn & pl_req_valid & ~w_flush;
    assign w_dbg_cand  = resetn & dbg_req_valid;
    assign w_is_write  = (r_op == OP_WR) || (r_op == OP_XCHG);
    assign w_pl_cancel = w_flush & ~r_owner & ((r_state == S_RD) || (r_state == S_WR));
    assign w_rsp_valid = (r_state == S_RSP);
    assign w_hs        = w_rsp_valid & (r_owner ? dbg_rsp_ready : pl_rsp_ready);

    always_comb begin
        w_gnt_pl  = 1'b0;
        w_gnt_dbg = 1'b0;
        if (r_state == S_IDLE) begin
            if (ARB_MODE == 1) begin
                w_gnt_dbg = w_dbg_cand;
                w_gnt_pl  = w_pl_cand & ~w_dbg_cand;
            end else if (w_pl_cand && w_dbg_cand) begin
                w_gnt_pl  = r_last;
                w_gnt_dbg = ~r_last;
            end else begin
                w_gnt_pl  = w_pl_cand;
                w_gnt_dbg = w_dbg_cand;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_gnt_pl || w_gnt_dbg) w_state_nxt = S_RD;
            S_RD: begin
                if (w_pl_cancel)     w_state_nxt = S_IDLE;
                else if (w_is_write) w_state_nxt = S_WR;
                else                 w_state_nxt = S_RSP;
            end
            // A flushed debug write stays here and retries.
            S_WR: begin
                if (w_pl_cancel)   w_state_nxt = S_IDLE;
                else if (!w_flush) w_state_nxt = S_RSP;
            end
            S_RSP:   if (w_hs) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_last       <= 1'b1;
            r_owner      <= 1'b0;
            r_op         <= OP_RD;
            r_num        <= '0;
            r_wdata      <= '0;
            r_wmask      <= '0;
            r_csr_wmask  <= '0;
            r_csr_wvalue <= '0;
            r_pl_rdata   <= '0;
            r_dbg_rdata  <= '0;
        end else begin
            if (w_gnt_pl || w_gnt_dbg) begin
                r_owner <= w_gnt_dbg;
                r_last  <= w_gnt_dbg;
                r_op    <= op_t'(w_gnt_dbg ? dbg_op : pl_op);
                r_num   <= w_gnt_dbg ? dbg_num : pl_num;
                r_wdata <= w_gnt_dbg ? dbg_wdata : pl_wdata;
                r_wmask <= w_gnt_dbg ? dbg_wmask : pl_wmask;
            end
            if ((r_state == S_RD) && !w_pl_cancel) begin
                if (r_owner) r_dbg_rdata <= csr_rvalue;
                else         r_pl_rdata  <= csr_rvalue;
                if (w_is_write) begin
                    r_csr_wvalue <= r_wdata;
                    r_csr_wmask  <= (r_op == OP_XCHG) ? r_wmask : '1;
                end
            end
        end
    end

    assign pl_req_ready  = w_gnt_pl;
    assign dbg_req_ready = w_gnt_dbg;
    assign pl_rsp_valid  = w_rsp_valid & ~r_owner;
    assign dbg_rsp_valid = w_rsp_valid & r_owner;
    assign pl_rdata      = r_pl_rdata;
    assign dbg_rdata     = r_dbg_rdata;
    assign csr_we        = (r_state == S_WR) & ~w_flush;
    assign csr_num       = r_num;
    assign csr_wmask     = r_csr_wmask;
    assign csr_wvalue    = r_csr_wvalue;
    assign busy          = (r_state != S_IDLE);

`ifdef CSR_ACC_PERF_EN
    logic [31:0] r_perf_acc_cnt;
    logic [31:0] r_perf_cancel_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_perf_acc_cnt    <= '0;
            r_perf_cancel_cnt <= '0;
        end else begin
            if (w_hs)        r_perf_acc_cnt    <= r_perf_acc_cnt + 32'd1;
            if (w_pl_cancel) r_perf_cancel_cnt <= r_perf_cancel_cnt + 32'd1;
        end
    end

    assign perf_acc_cnt    = r_perf_acc_cnt;
    assign perf_cancel_cnt = r_perf_cancel_cnt;
`endif

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Bench for csr_access_ctrl: table-driven single accesses, flush/stall/reset sequences, and
// arbitration on a round-robin instance plus a debug-priority instance sharing the same inputs.
module tb_csr_access_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        pl_req_valid = 1'b0, dbg_req_valid = 1'b0;
    logic [1:0]  pl_op = '0, dbg_op = '0;
    logic [13:0] pl_num = '0, dbg_num = '0;
    logic [31:0] pl_wdata = '0, pl_wmask = '0, dbg_wdata = '0, dbg_wmask = '0;
    logic        pl_rsp_ready = 1'b1, dbg_rsp_ready = 1'b1;
    logic        wb_ex = 1'b0, ertn_flush = 1'b0;

    logic        pl_req_ready, dbg_req_ready, pl_rsp_valid, dbg_rsp_valid, csr_we, busy;
    logic [31:0] pl_rdata, dbg_rdata, csr_wmask, csr_wvalue, csr_rvalue;
    logic [13:0] csr_num;
    logic        m1_pl_req_ready, m1_dbg_req_ready, m1_pl_rsp_valid, m1_dbg_rsp_valid, m1_csr_we, m1_busy;
    logic [31:0] m1_pl_rdata, m1_dbg_rdata, m1_csr_wmask, m1_csr_wvalue, m1_csr_rvalue;
    logic [13:0] m1_csr_num;
`ifdef CSR_ACC_PERF_EN
    logic [31:0] perf_acc_cnt, perf_cancel_cnt, m1_perf_acc_cnt, m1_perf_cancel_cnt;
`endif

    csr_access_ctrl #(.NUM_W(14), .DATA_W(32), .ARB_MODE(0)) dut (
        .clk(clk), .resetn(resetn),
        .pl_req_valid(pl_req_valid), .pl_req_ready(pl_req_ready), .pl_op(pl_op), .pl_num(pl_num),
        .pl_wdata(pl_wdata), .pl_wmask(pl_wmask), .pl_rsp_valid(pl_rsp_valid),
        .pl_rsp_ready(pl_rsp_ready), .pl_rdata(pl_rdata),
        .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready), .dbg_op(dbg_op), .dbg_num(dbg_num),
        .dbg_wdata(dbg_wdata), .dbg_wmask(dbg_wmask), .dbg_rsp_valid(dbg_rsp_valid),
        .dbg_rsp_ready(dbg_rsp_ready), .dbg_rdata(dbg_rdata),
        .wb_ex(wb_ex), .ertn_flush(ertn_flush),
        .csr_we(csr_we), .csr_num(csr_num), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
        .csr_rvalue(csr_rvalue), .busy(busy)
`ifdef CSR_ACC_PERF_EN
        , .perf_acc_cnt(perf_acc_cnt), .perf_cancel_cnt(perf_cancel_cnt)
`endif
    );

    csr_access_ctrl #(.NUM_W(14), .DATA_W(32), .ARB_MODE(1)) dut_prio (
        .clk(clk), .resetn(resetn),
        .pl_req_valid(pl_req_valid), .pl_req_ready(m1_pl_req_ready), .pl_op(pl_op), .pl_num(pl_num),
        .pl_wdata(pl_wdata), .pl_wmask(pl_wmask), .pl_rsp_valid(m1_pl_rsp_valid),
        .pl_rsp_ready(pl_rsp_ready), .pl_rdata(m1_pl_rdata),
        .dbg_req_valid(dbg_req_valid), .dbg_req_ready(m1_dbg_req_ready), .dbg_op(dbg_op), .dbg_num(dbg_num),
        .dbg_wdata(dbg_wdata), .dbg_wmask(dbg_wmask), .dbg_rsp_valid(m1_dbg_rsp_valid),
        .dbg_rsp_ready(dbg_rsp_ready), .dbg_rdata(m1_dbg_rdata),
        .wb_ex(wb_ex), .ertn_flush(ertn_flush),
        .csr_we(m1_csr_we), .csr_num(m1_csr_num), .csr_wmask(m1_csr_wmask), .csr_wvalue(m1_csr_wvalue),
        .csr_rvalue(m1_csr_rvalue), .busy(m1_busy)
`ifdef CSR_ACC_PERF_EN
        , .perf_acc_cnt(m1_perf_acc_cnt), .perf_cancel_cnt(m1_perf_cancel_cnt)
`endif
    );

    always #5 clk = ~clk;

    // CSR file model: CRMD(0)=0x8, SAVE0(0x30)=0x12345678, SAVE1(0x31)=0xCAFEF00D after reset.
    logic [31:0] mem [0:63];
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
            mem[0]     <= 32'h0000_0008;
            mem[6'h30] <= 32'h1234_5678;
            mem[6'h31] <= 32'hCAFE_F00D;
        end else if (csr_we) begin
            mem[csr_num[5:0]] <= (mem[csr_num[5:0]] & ~csr_wmask) | (csr_wvalue & csr_wmask);
        end
    end
    assign csr_rvalue    = mem[csr_num[5:0]];
    assign m1_csr_rvalue = mem[m1_csr_num[5:0]];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    logic [31:0] q_pl[$];
    logic [31:0] q_dbg[$];

    always @(negedge clk) begin
        if (resetn && pl_rsp_valid && pl_rsp_ready) begin
            if (q_pl.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL pl_rsp_unexpected: got rdata 0x%08h with no pending request", pl_rdata);
            end else chk("pl_rdata_sb", pl_rdata, q_pl.pop_front());
        end
        if (resetn && dbg_rsp_valid && dbg_rsp_ready) begin
            if (q_dbg.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL dbg_rsp_unexpected: got rdata 0x%08h with no pending request", dbg_rdata);
            end else chk("dbg_rdata_sb", dbg_rdata, q_dbg.pop_front());
        end
    end

    typedef struct {
        logic        dbg;
        logic [1:0]  op;
        logic [13:0] num;
        logic [31:0] wdata;
        logic [31:0] wmask;
        logic        exp_we;
        logic [31:0] exp_wmask;
        logic [31:0] exp_rdata;
        logic [31:0] exp_new;
    } vec_t;

    task automatic run_vec(input vec_t v, input int idx);
        int          rsp_cyc = -1;
        int          we_cnt  = 0;
        int          we_cyc  = -1;
        logic [31:0] we_mask = '0, we_val = '0;
        logic [13:0] we_num  = '0;
        @(posedge clk); #2;
        if (v.dbg) begin
            dbg_req_valid = 1'b1; dbg_op = v.op; dbg_num = v.num; dbg_wdata = v.wdata; dbg_wmask = v.wmask;
        end else begin
            pl_req_valid = 1'b1; pl_op = v.op; pl_num = v.num; pl_wdata = v.wdata; pl_wmask = v.wmask;
        end
        @(negedge clk);
        chk($sformatf("v%0d_req_ready", idx), {31'd0, v.dbg ? dbg_req_ready : pl_req_ready}, 32'd1);
        if (v.dbg) q_dbg.push_back(v.exp_rdata);
        else       q_pl.push_back(v.exp_rdata);
        @(posedge clk); #2;
        pl_req_valid = 1'b0; dbg_req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) chk($sformatf("v%0d_busy", idx), {31'd0, busy}, 32'd1);
            if (csr_we) begin
                we_cnt++; we_cyc = c; we_mask = csr_wmask; we_val = csr_wvalue; we_num = csr_num;
            end
            if (v.dbg ? dbg_rsp_valid : pl_rsp_valid) begin
                rsp_cyc = c;
                break;
            end
        end
        chk($sformatf("v%0d_rsp_latency", idx), rsp_cyc, v.exp_we ? 32'd3 : 32'd2);
        chk($sformatf("v%0d_we_count", idx), we_cnt, {31'd0, v.exp_we});
        if (v.exp_we) begin
            chk($sformatf("v%0d_we_cycle", idx), we_cyc, 32'd2);
            chk($sformatf("v%0d_wmask", idx), we_mask, v.exp_wmask);
            chk($sformatf("v%0d_wvalue", idx), we_val, v.wdata);
            chk($sformatf("v%0d_wnum", idx), {18'd0, we_num}, {18'd0, v.num});
        end
        @(posedge clk); #2;
        chk($sformatf("v%0d_csr_after", idx), mem[v.num[5:0]], v.exp_new);
        chk($sformatf("v%0d_idle_after", idx), {31'd0, busy}, 32'd0);
    endtask

    vec_t vecs[8];
    int   seq0[$];
    int   seq1[$];

    initial begin
        vecs[0] = '{1'b0, 2'b00, 14'h030, 32'h0,         32'h0,         1'b0, 32'h0,         32'h1234_5678, 32'h1234_5678};
        vecs[1] = '{1'b0, 2'b10, 14'h000, 32'h7,         32'h4,         1'b1, 32'h4,         32'h8,         32'hC};
        vecs[2] = '{1'b1, 2'b00, 14'h031, 32'h0,         32'h0,         1'b0, 32'h0,         32'hCAFE_F00D, 32'hCAFE_F00D};
        vecs[3] = '{1'b1, 2'b01, 14'h031, 32'hA5A5_0001, 32'h0,         1'b1, 32'hFFFF_FFFF, 32'hCAFE_F00D, 32'hA5A5_0001};
        vecs[4] = '{1'b0, 2'b11, 14'h030, 32'h0000_DEAD, 32'hFFFF_FFFF, 1'b0, 32'h0,         32'h1234_5678, 32'h1234_5678};
        vecs[5] = '{1'b0, 2'b01, 14'h030, 32'h1,         32'h0,         1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 32'h1};
        vecs[6] = '{1'b0, 2'b00, 14'h030, 32'h0,         32'h0,         1'b0, 32'h0,         32'h1,         32'h1};
        vecs[7] = '{1'b1, 2'b10, 14'h000, 32'hFFFF_FFF0, 32'h0000_00F0, 1'b1, 32'h0000_00F0, 32'hC,         32'hFC};

        // Reset state
        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_csr_we", {31'd0, csr_we}, 32'd0);
        chk("rst_csr_num", {18'd0, csr_num}, 32'd0);
        chk("rst_pl_rdata", pl_rdata, 32'd0);
        chk("rst_pl_rsp_valid", {31'd0, pl_rsp_valid}, 32'd0);
        @(posedge clk); #2;
        resetn = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);
`ifdef CSR_ACC_PERF_EN
        chk("perf_acc_after_table", perf_acc_cnt, 32'd8);
`endif

        // Pipeline WR cancelled by wb_ex in the WR cycle
        @(posedge clk); #2;
        pl_req_valid = 1'b1; pl_op = 2'b01; pl_num = 14'h030; pl_wdata = 32'hBAD0_BAD0; pl_wmask = '0;
        @(negedge clk);
        chk("cancel_req_ready", {31'd0, pl_req_ready}, 32'd1);
        @(posedge clk); #2; pl_req_valid = 1'b0;
        @(posedge clk); #2; wb_ex = 1'b1;
        @(negedge clk);
        chk("cancel_we_low", {31'd0, csr_we}, 32'd0);
        chk("cancel_busy_wr", {31'd0, busy}, 32'd1);
        @(posedge clk); #2; wb_ex = 1'b0;
        @(negedge clk);
        chk("cancel_idle", {31'd0, busy}, 32'd0);
        chk("cancel_no_rsp", {31'd0, pl_rsp_valid}, 32'd0);
        chk("cancel_csr_kept", mem[6'h30], 32'h1);
`ifdef CSR_ACC_PERF_EN
        chk("perf_cancel", perf_cancel_cnt, 32'd1);
`endif
        repeat (3) @(negedge clk);

        // Debug WR with ertn_flush held for two WR cycles
        @(posedge clk); #2;
        dbg_req_valid = 1'b1; dbg_op = 2'b01; dbg_num = 14'h031; dbg_wdata = 32'h0F0F_0F0F; dbg_wmask = '0;
        @(negedge clk);
        chk("dflush_req_ready", {31'd0, dbg_req_ready}, 32'd1);
        q_dbg.push_back(32'hA5A5_0001);
        @(posedge clk); #2; dbg_req_valid = 1'b0;
        @(posedge clk); #2; ertn_flush = 1'b1;
        @(negedge clk);
        chk("dflush_we_c2", {31'd0, csr_we}, 32'd0);
        @(negedge clk);
        chk("dflush_we_c3", {31'd0, csr_we}, 32'd0);
        chk("dflush_busy", {31'd0, busy}, 32'd1);
        @(posedge clk); #2; ertn_flush = 1'b0;
        @(negedge clk);
        chk("dflush_we_c4", {31'd0, csr_we}, 32'd1);
        chk("dflush_wvalue", csr_wvalue, 32'h0F0F_0F0F);
        chk("dflush_wmask", csr_wmask, 32'hFFFF_FFFF);
        chk("dflush_no_rsp_yet", {31'd0, dbg_rsp_valid}, 32'd0);
        @(negedge clk);
        chk("dflush_rsp_valid", {31'd0, dbg_rsp_valid}, 32'd1);
        @(posedge clk); #2;
        chk("dflush_csr_after", mem[6'h31], 32'h0F0F_0F0F);

        // Response stall for 5 cycles, then asynchronous reset mid-RSP
        pl_rsp_ready = 1'b0;
        pl_req_valid = 1'b1; pl_op = 2'b00; pl_num = 14'h000;
        @(negedge clk);
        chk("stall_req_ready", {31'd0, pl_req_ready}, 32'd1);
        @(posedge clk); #2;
        pl_req_valid = 1'b0;
        dbg_req_valid = 1'b1; dbg_op = 2'b00; dbg_num = 14'h031;
        @(negedge clk);
        for (int c = 2; c <= 6; c++) begin
            @(negedge clk);
            chk($sformatf("stall_rsp_valid_c%0d", c), {31'd0, pl_rsp_valid}, 32'd1);
            chk($sformatf("stall_rdata_c%0d", c), pl_rdata, 32'h0000_00FC);
            chk($sformatf("stall_no_grant_c%0d", c), {31'd0, dbg_req_ready}, 32'd0);
        end
        #1 resetn = 1'b0;
        #1;
        chk("arst_pl_req_ready", {31'd0, pl_req_ready}, 32'd0);
        chk("arst_dbg_req_ready", {31'd0, dbg_req_ready}, 32'd0);
        chk("arst_pl_rsp_valid", {31'd0, pl_rsp_valid}, 32'd0);
        chk("arst_dbg_rsp_valid", {31'd0, dbg_rsp_valid}, 32'd0);
        chk("arst_pl_rdata", pl_rdata, 32'd0);
        chk("arst_dbg_rdata", dbg_rdata, 32'd0);
        chk("arst_csr_we", {31'd0, csr_we}, 32'd0);
        chk("arst_csr_num", {18'd0, csr_num}, 32'd0);
        chk("arst_csr_wmask", csr_wmask, 32'd0);
        chk("arst_csr_wvalue", csr_wvalue, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        dbg_req_valid = 1'b0;
        pl_rsp_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #2 resetn = 1'b1;

        // Both requesters valid every cycle: round-robin vs debug priority
        @(posedge clk); #2;
        pl_req_valid  = 1'b1; pl_op  = 2'b00; pl_num  = 14'h030;
        dbg_req_valid = 1'b1; dbg_op = 2'b00; dbg_num = 14'h031;
        for (int c = 0; c < 40 && (seq0.size() < 6 || seq1.size() < 6); c++) begin
            @(negedge clk);
            if (pl_req_ready)     begin seq0.push_back(0); q_pl.push_back(32'h1234_5678); end
            if (dbg_req_ready)    begin seq0.push_back(1); q_dbg.push_back(32'hCAFE_F00D); end
            if (m1_pl_req_ready)  seq1.push_back(0);
            if (m1_dbg_req_ready) seq1.push_back(1);
        end
        @(posedge clk); #2;
        pl_req_valid = 1'b0; dbg_req_valid = 1'b0;
        chk("rr_grant_count", seq0.size(), 32'd6);
        chk("prio_grant_count", seq1.size(), 32'd6);
        for (int i = 0; i < 6 && i < seq0.size(); i++)
            chk($sformatf("rr_grant_%0d", i), seq0[i], i % 2);
        for (int i = 0; i < 6 && i < seq1.size(); i++)
            chk($sformatf("prio_grant_%0d", i), seq1[i], 32'd1);
        for (int c = 0; c < 10 && (q_pl.size() != 0 || q_dbg.size() != 0); c++) @(negedge clk);
        chk("sb_pl_drained", q_pl.size(), 32'd0);
        chk("sb_dbg_drained", q_dbg.size(), 32'd0);
        chk("prio_dbg_rdata", m1_dbg_rdata, 32'hCAFE_F00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/csr_access_ctrl.md
Name: csr_access_ctrl

Overview:
- Sequences every access to the CSR register file and arbitrates between two requesters: the pipeline (csrrd/csrwr/csrxchg issued from WB) and a debug port.
- Each access is a read phase followed by an optional write phase. The old value is always returned to the requester.
- The write is suppressed when an exception or ertn flush coincides with it, because the register file does not prioritise wb_ex over csr_we for every register.
- Sits between the WB stage / debug unit and the CSR file; it is the only driver of the file's csr_we/csr_num/csr_wmask/csr_wvalue.

Parameters:
- NUM_W, 14, CSR number width.
- DATA_W, 32, CSR data width.
- ARB_MODE, 0, 0 = round-robin between pipeline and debug; 1 = fixed priority, debug first.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- pl_req_valid  in  1  pipeline request valid
- pl_req_ready  out  1  pipeline request accepted
- pl_op  in  2  00 RD, 01 WR (full-mask write), 10 XCHG (masked write), 11 reserved (treated as RD, no write)
- pl_num  in  NUM_W  CSR number
- pl_wdata  in  DATA_W  write data
- pl_wmask  in  DATA_W  write mask; used only for XCHG
- pl_rsp_valid  out  1  pipeline response valid
- pl_rsp_ready  in  1  pipeline response taken
- pl_rdata  out  DATA_W  old CSR value
- dbg_req_valid, dbg_req_ready, dbg_op, dbg_num, dbg_wdata, dbg_wmask, dbg_rsp_valid, dbg_rsp_ready, dbg_rdata: same directions and widths as the pl_ ports
- wb_ex  in  1  WB exception commit
- ertn_flush  in  1  ertn commit
- csr_we  out  1  to CSR file
- csr_num  out  NUM_W  to CSR file
- csr_wmask  out  DATA_W  to CSR file
- csr_wvalue  out  DATA_W  to CSR file
- csr_rvalue  in  DATA_W  from CSR file (combinational read)
- busy  out  1  controller not in IDLE

Behaviour:
- Reset:
  - State IDLE.
  - Outputs zero: all *_ready, *_rsp_valid, *_rdata, csr_we, csr_num, csr_wmask, csr_wvalue, busy.
  - Round-robin pointer last = debug, so the pipeline wins the first tie.
- flush = wb_ex | ertn_flush.
- FSM states: IDLE, RD, WR, RSP.
- IDLE:
  - Candidates are pl_req_valid & ~flush, and dbg_req_valid.
  - If ARB_MODE=0, grant the requester other than last when both request; otherwise grant whichever requests.
  - If ARB_MODE=1, debug always wins.
  - On grant: pulse the granted *_req_ready for one cycle (same cycle as the grant); latch op/num/wdata/mask and owner; update last; go to RD.
  - Ready is combinational from valid; requesters hold request fields stable while valid.
- RD:
  - csr_num = latched num; capture csr_rvalue into the owner's rdata register.
  - RD or reserved op: go to RSP.
  - WR or XCHG: go to WR.
- WR:
  - csr_we = 1 for exactly this cycle, except as below; csr_num = latched num.
  - csr_wvalue = wdata.
  - csr_wmask = all ones for WR, latched mask for XCHG.
  - If flush is high this cycle: csr_we = 0.
    - Pipeline owner: the access is cancelled, no response, go to IDLE.
    - Debug owner: the write is retried in WR next cycle, until flush is low.
  - Otherwise go to RSP.
- RD state with flush high and pipeline owner: cancel, no response, go to IDLE.
- RSP:
  - The owner's rsp_valid = 1 and rdata is held until rsp_ready; the handshake completes in the cycle both are high, then go to IDLE.
  - rsp_valid is never retracted except by reset.
- Latency from the grant cycle:
  - RD: rsp_valid at cycle +2.
  - WR/XCHG: rsp_valid at cycle +3 (no flush).
- Throughput: the next grant occurs no earlier than the cycle after the response handshake.
- csr_num/csr_wmask/csr_wvalue hold their last values outside RD/WR; csr_we is 0 outside WR.
- busy = (state != IDLE).
- Reset asserted mid-access: immediately return to IDLE; any in-flight write is dropped and no response is issued.

Optional Feature:
- Macro CSR_ACC_PERF_EN.
- Defined:
  - Adds outputs perf_acc_cnt[31:0] and perf_cancel_cnt[31:0], both reset to 0.
  - perf_acc_cnt increments on each completed response handshake.
  - perf_cancel_cnt increments on each pipeline cancel.
  - Both wrap from 0xFFFFFFFF to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- pl RD of num 0x0030 (SAVE0 = 0x12345678) -> pl_req_ready at cycle 0, csr_we never set, pl_rsp_valid at cycle 2, pl_rdata = 0x12345678.
- pl XCHG of num 0x0000, wdata 0x7, mask 0x4, CRMD = 0x8 -> csr_we one cycle at cycle 2 with wmask 0x4 and wvalue 0x7; response rdata = 0x8.
- pl WR with wb_ex = 1 in the WR cycle -> csr_we stays 0, no pl_rsp_valid, back in IDLE next cycle; perf_cancel_cnt = 1 (macro on).
- dbg WR with ertn_flush high for 2 cycles in WR -> csr_we held off 2 cycles and asserted on cycle 3 of WR; dbg_rsp_valid follows.
- pl and dbg both valid every cycle, ARB_MODE = 0 -> grants alternate pl, dbg, pl, dbg; with ARB_MODE = 1, dbg is granted every time.
- pl_rsp_ready held low for 5 cycles -> rsp_valid and rdata stable, no new grant; resetn pulsed low mid-RSP -> all outputs 0 asynchronously.
